// File: rtl/spi_slave_byte.sv
// spi_slave_byte: byte-wide SPI responder (target), oversampled in the clk_i domain.
//
// The SPI pins are synchronized into clk_i and edges are detected there. Data moves full
// duplex, MSB first. Received bytes are presented on rx_byte_o with a one-cycle rx_dv_o pulse.
// Transmit bytes enter through a single-entry holding register using a ready/valid handshake.
// When a byte boundary finds the holding register empty, DEFAULT_TX is sent instead and
// underrun_o pulses.
//
// Ports:
//   clk_i, rst_i       system clock, asynchronous active-high reset
//   sck_i, cs_i        SPI clock and active-low select from the master (asynchronous)
//   mosi_i             master-out data (asynchronous)
//   miso_o, miso_oe_o  slave-out data and its output enable (1 while selected)
//   tx_byte_i/tx_dv_i  transmit byte offered to the holding register
//   tx_ready_o         holding register empty
//   rx_byte_o/rx_dv_o  last complete received byte, one-cycle valid pulse
//   underrun_o         one-cycle pulse when a byte boundary falls back to DEFAULT_TX
//
// The design works only if the clk_i period is at most 1/8 of the sck period.
module spi_slave_byte #(
    parameter bit         CPOL       = 1'b0,
    parameter bit         CPHA       = 1'b0,
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       cs_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_dv_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_dv_o,
    output logic       underrun_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // Synchronizer stages (s1, s2) plus a history flop for edge detection.
    logic sck_s1_q, sck_s2_q, sck_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q, mosi_h_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    // Set when tx_shift_q[7] has been loaded but not yet driven onto miso.
    logic       tx_fresh_q, tx_fresh_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic       underrun_q, underrun_d;

    logic       sck_rise, sck_fall;
    logic       lead_edge, trail_edge;
    logic       sample_edge, shift_edge;
    logic       cs_fall, cs_rise;
    logic       tx_accept;
    logic       load;
    logic [7:0] load_byte;

    assign sck_rise    = sck_s2_q & ~sck_h_q;
    assign sck_fall    = ~sck_s2_q & sck_h_q;
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_s2_q & cs_h_q;
    assign cs_rise     = cs_s2_q & ~cs_h_q;
    assign tx_accept   = tx_dv_i & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_fresh_d  = tx_fresh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;
        load_byte   = DEFAULT_TX;

        case (state_q)
            StIdle: begin
                miso_oe_d = 1'b0;
                if (cs_fall) begin
                    state_d    = StActive;
                    miso_oe_d  = 1'b1;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                    load       = 1'b1;
                end
            end
            StActive: begin
                miso_oe_d = 1'b1;
                if (cs_rise) begin
                    // Deselect drops any partial byte; holding register keeps its byte.
                    state_d    = StIdle;
                    miso_oe_d  = 1'b0;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[6:0], mosi_h_q};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            rx_byte_d = {rx_shift_q[6:0], mosi_h_q};
                            rx_dv_d   = 1'b1;
                            load      = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                    if (shift_edge) begin
                        if (tx_fresh_q) begin
                            miso_d     = tx_shift_q[7];
                            tx_fresh_d = 1'b0;
                        end else begin
                            miso_d     = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Byte boundary reload: a byte offered in this same cycle lands in holding, not here.
        if (load) begin
            if (hold_full_q) begin
                load_byte   = hold_q;
                hold_full_d = 1'b0;
            end else begin
                load_byte  = DEFAULT_TX;
                underrun_d = 1'b1;
            end
            tx_shift_d = load_byte;
            // CPHA=0 drives the first MSB at select; every other case waits for a shift edge.
            if (!CPHA && state_q == StIdle) begin
                miso_d     = load_byte[7];
                tx_fresh_d = 1'b0;
            end else begin
                tx_fresh_d = 1'b1;
            end
        end

        if (tx_accept) begin
            hold_d      = tx_byte_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_s1_q    <= CPOL;
            sck_s2_q    <= CPOL;
            sck_h_q     <= CPOL;
            // cs history resets as if selected, so a select held through reset release
            // produces no falling edge until cs_i has been seen high.
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_h_q      <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            mosi_h_q    <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            tx_fresh_q  <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_dv_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sck_s1_q    <= sck_i;
            sck_s2_q    <= sck_s1_q;
            sck_h_q     <= sck_s2_q;
            cs_s1_q     <= cs_i;
            cs_s2_q     <= cs_s1_q;
            cs_h_q      <= cs_s2_q;
            mosi_s1_q   <= mosi_i;
            mosi_s2_q   <= mosi_s1_q;
            mosi_h_q    <= mosi_s2_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_fresh_q  <= tx_fresh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            underrun_q  <= underrun_d;
        end
    end

    assign miso_o     = miso_q;
    assign miso_oe_o  = miso_oe_q;
    assign tx_ready_o = ~hold_full_q;
    assign rx_byte_o  = rx_byte_q;
    assign rx_dv_o    = rx_dv_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: one DUT per SPI mode (index = CPOL*2 + CPHA), each with its own
// pins, driven by a simple SPI master model with hand-computed expected bytes.
module tb_spi_slave_byte;

    localparam int HALF = 100;  // half sck period in ns; clk_i period is 10 ns

    logic       clk = 1'b0;
    logic       rst;
    logic       sck      [4];
    logic       cs       [4];
    logic       mosi     [4];
    logic       tx_dv    [4];
    logic [7:0] tx_byte  [4];
    logic       miso     [4];
    logic       miso_oe  [4];
    logic       tx_ready [4];
    logic       rx_dv    [4];
    logic       underrun [4];
    logic [7:0] rx_byte  [4];

    int checks = 0;
    int errors = 0;
    int rx_dv_cnt [4];
    int un_cnt    [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_byte #(
            .CPOL      (bit'(g / 2)),
            .CPHA      (bit'(g % 2)),
            .DEFAULT_TX(8'hFF)
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .sck_i     (sck[g]),
            .cs_i      (cs[g]),
            .mosi_i    (mosi[g]),
            .miso_o    (miso[g]),
            .miso_oe_o (miso_oe[g]),
            .tx_byte_i (tx_byte[g]),
            .tx_dv_i   (tx_dv[g]),
            .tx_ready_o(tx_ready[g]),
            .rx_byte_o (rx_byte[g]),
            .rx_dv_o   (rx_dv[g]),
            .underrun_o(underrun[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_dv[k] === 1'b1) rx_dv_cnt[k]++;
            if (underrun[k] === 1'b1) un_cnt[k]++;
        end
    end

    task automatic clear_counts(input int m);
        rx_dv_cnt[m] = 0;
        un_cnt[m]    = 0;
    endtask

    task automatic push(input int m, input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        while (tx_ready[m] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx_ready[m] !== 1'b1) begin
            errors++;
            $display("FAIL push_ready m%0d: got %b expected 1", m, tx_ready[m]);
        end
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m]   = 1'b0;
        checks++;
        if (tx_ready[m] !== 1'b0) begin
            errors++;
            $display("FAIL push_ready_fall m%0d: got %b expected 0", m, tx_ready[m]);
        end
    endtask

    task automatic cs_low(input int m);
        cs[m] = 1'b0;
        #HALF;
    endtask

    task automatic cs_high(input int m);
        #HALF;
        cs[m] = 1'b1;
        #HALF;
    endtask

    // Shifts the top n bits of mo out, MSB first; returns what the master sampled on miso.
    task automatic spi_bits(input int m, input logic [7:0] mo, input int n,
                            output logic [7:0] mi);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        mi   = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            if (!cpha) begin
                mosi[m] = mo[i];
                #HALF;
                sck[m]  = ~cpol;
                mi[i]   = miso[m];
                #HALF;
                sck[m]  = cpol;
            end else begin
                sck[m]  = ~cpol;
                mosi[m] = mo[i];
                #HALF;
                mi[i]   = miso[m];
                sck[m]  = cpol;
                #HALF;
            end
        end
    endtask

    task automatic test_reset;
        for (int m = 0; m < 4; m++) begin
            checks++;
            if ({miso[m], miso_oe[m], tx_ready[m], rx_dv[m], underrun[m], rx_byte[m]} !==
                {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_vals m%0d: got %b%b%b%b%b %h expected 10100 00", m,
                         miso[m], miso_oe[m], tx_ready[m], rx_dv[m], underrun[m], rx_byte[m]);
            end
        end
    endtask

    task automatic test_mode0_basic;
        logic [7:0] mi;
        clear_counts(0);
        push(0, 8'hA5);
        // Offered while the holding register is full: must be dropped.
        @(negedge clk);
        tx_byte[0] = 8'h5E;
        tx_dv[0]   = 1'b1;
        @(negedge clk);
        tx_dv[0]   = 1'b0;
        cs_low(0);
        checks++;
        if (miso_oe[0] !== 1'b1) begin
            errors++;
            $display("FAIL mode0_oe_on: got %b expected 1", miso_oe[0]);
        end
        push(0, 8'h00);
        spi_bits(0, 8'h3C, 8, mi);
        cs_high(0);
        checks++;
        if (mi !== 8'hA5) begin
            errors++;
            $display("FAIL mode0_miso: got %h expected a5", mi);
        end
        checks++;
        if (rx_byte[0] !== 8'h3C) begin
            errors++;
            $display("FAIL mode0_rx: got %h expected 3c", rx_byte[0]);
        end
        checks++;
        if (rx_dv_cnt[0] !== 1) begin
            errors++;
            $display("FAIL mode0_rx_dv_count: got %0d expected 1", rx_dv_cnt[0]);
        end
        checks++;
        if (un_cnt[0] !== 0) begin
            errors++;
            $display("FAIL mode0_underrun_count: got %0d expected 0", un_cnt[0]);
        end
        checks++;
        if (miso_oe[0] !== 1'b0) begin
            errors++;
            $display("FAIL mode0_oe_off: got %b expected 0", miso_oe[0]);
        end
    endtask

    task automatic test_modes;
        logic [7:0] mi;
        for (int m = 1; m < 4; m++) begin
            clear_counts(m);
            push(m, 8'h7E);
            cs_low(m);
            push(m, 8'h00);
            spi_bits(m, 8'h81, 8, mi);
            cs_high(m);
            checks++;
            if (mi !== 8'h7E) begin
                errors++;
                $display("FAIL mode%0d_miso: got %h expected 7e", m, mi);
            end
            checks++;
            if (rx_byte[m] !== 8'h81) begin
                errors++;
                $display("FAIL mode%0d_rx: got %h expected 81", m, rx_byte[m]);
            end
            checks++;
            if (rx_dv_cnt[m] !== 1) begin
                errors++;
                $display("FAIL mode%0d_rx_dv_count: got %0d expected 1", m, rx_dv_cnt[m]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] mi1, mi2;
        clear_counts(0);
        push(0, 8'hC3);
        cs_low(0);
        push(0, 8'h5A);
        spi_bits(0, 8'h11, 8, mi1);
        checks++;
        if (rx_byte[0] !== 8'h11) begin
            errors++;
            $display("FAIL b2b_rx_first: got %h expected 11", rx_byte[0]);
        end
        spi_bits(0, 8'h22, 8, mi2);
        cs_high(0);
        checks++;
        if (mi1 !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_miso_first: got %h expected c3", mi1);
        end
        checks++;
        if (mi2 !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_miso_second: got %h expected 5a", mi2);
        end
        checks++;
        if (rx_byte[0] !== 8'h22) begin
            errors++;
            $display("FAIL b2b_rx_second: got %h expected 22", rx_byte[0]);
        end
        checks++;
        if (rx_dv_cnt[0] !== 2) begin
            errors++;
            $display("FAIL b2b_rx_dv_count: got %0d expected 2", rx_dv_cnt[0]);
        end
    endtask

    task automatic test_underrun;
        logic [7:0] mi;
        checks++;
        if (tx_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL underrun_hold_empty: got %b expected 1", tx_ready[0]);
        end
        clear_counts(0);
        cs_low(0);
        checks++;
        if (un_cnt[0] !== 1) begin
            errors++;
            $display("FAIL underrun_at_select: got %0d expected 1", un_cnt[0]);
        end
        // Refill so the end-of-byte reload does not underrun again.
        push(0, 8'h99);
        spi_bits(0, 8'h00, 8, mi);
        cs_high(0);
        checks++;
        if (mi !== 8'hFF) begin
            errors++;
            $display("FAIL underrun_miso: got %h expected ff", mi);
        end
        checks++;
        if (un_cnt[0] !== 1) begin
            errors++;
            $display("FAIL underrun_count: got %0d expected 1", un_cnt[0]);
        end
        checks++;
        if (rx_byte[0] !== 8'h00 || rx_dv_cnt[0] !== 1) begin
            errors++;
            $display("FAIL underrun_rx: got %h/%0d expected 00/1", rx_byte[0], rx_dv_cnt[0]);
        end
    endtask

    task automatic test_cs_abort;
        logic [7:0] mi;
        clear_counts(0);
        cs_low(0);
        spi_bits(0, 8'hFF, 5, mi);
        cs_high(0);
        checks++;
        if (rx_dv_cnt[0] !== 0) begin
            errors++;
            $display("FAIL abort_no_dv: got %0d expected 0", rx_dv_cnt[0]);
        end
        checks++;
        if (rx_byte[0] !== 8'h00) begin
            errors++;
            $display("FAIL abort_rx_held: got %h expected 00", rx_byte[0]);
        end
        cs_low(0);
        spi_bits(0, 8'hF0, 8, mi);
        cs_high(0);
        checks++;
        if (rx_byte[0] !== 8'hF0 || rx_dv_cnt[0] !== 1) begin
            errors++;
            $display("FAIL abort_next_rx: got %h/%0d expected f0/1", rx_byte[0], rx_dv_cnt[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] mi;
        cs_low(0);
        spi_bits(0, 8'hFF, 3, mi);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({miso[0], miso_oe[0], tx_ready[0], rx_dv[0], underrun[0], rx_byte[0]} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midreset_vals: got %b%b%b%b%b %h expected 10100 00", miso[0],
                     miso_oe[0], tx_ready[0], rx_dv[0], underrun[0], rx_byte[0]);
        end
        rst = 1'b0;
        clear_counts(0);
        repeat (10) @(negedge clk);
        checks++;
        if (miso_oe[0] !== 1'b0 || un_cnt[0] !== 0) begin
            errors++;
            $display("FAIL midreset_select_ignored: got oe %b underruns %0d expected 0 0",
                     miso_oe[0], un_cnt[0]);
        end
        push(0, 8'hA5);
        cs_high(0);
        cs_low(0);
        spi_bits(0, 8'h3C, 8, mi);
        cs_high(0);
        checks++;
        if (mi !== 8'hA5 || rx_byte[0] !== 8'h3C || rx_dv_cnt[0] !== 1) begin
            errors++;
            $display("FAIL midreset_next_xfer: got %h %h %0d expected a5 3c 1", mi,
                     rx_byte[0], rx_dv_cnt[0]);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int m = 0; m < 4; m++) begin
            sck[m]       = (m >= 2);
            cs[m]        = 1'b1;
            mosi[m]      = 1'b0;
            tx_dv[m]     = 1'b0;
            tx_byte[m]   = 8'h00;
            rx_dv_cnt[m] = 0;
            un_cnt[m]    = 0;
        end
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        test_reset();
        test_mode0_basic();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_cs_abort();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_byte.md
Name: spi_slave_byte

Overview:
- SPI responder (target) for the byte-wide SPI master on the Wishbone bus; it is the far end of the sck/cs/mosi/miso link.
- Oversamples the SPI pins in the system clock domain and shifts full-duplex, MSB first.
- Presents received bytes as a one-cycle valid pulse.
- Takes transmit bytes through a single-entry holding register with a ready/valid handshake.
- Used in the DV bench as the SPI device model and as a synthesizable peripheral-side endpoint.

Parameters:
- CPOL, 0, SCK idle level (0 = idle low, 1 = idle high).
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- DEFAULT_TX, 8'hFF, byte shifted out when no transmit byte is pending at a byte boundary.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  asynchronous active-high reset.
- sck_i  input  1  SPI clock from master, asynchronous to clk_i.
- cs_i  input  1  chip select from master, active low, asynchronous.
- mosi_i  input  1  master-out data, asynchronous.
- miso_o  output  1  slave-out data.
- miso_oe_o  output  1  miso output enable; 1 while selected.
- tx_byte_i  input  8  byte to transmit.
- tx_dv_i  input  1  tx_byte_i valid; accepted when tx_ready_o=1.
- tx_ready_o  output  1  holding register empty.
- rx_byte_o  output  8  last complete received byte; held until the next byte completes.
- rx_dv_o  output  1  one-cycle pulse when rx_byte_o updates.
- underrun_o  output  1  one-cycle pulse when a byte boundary finds no pending transmit byte.

Behaviour:
- Reset values: miso_o=1, miso_oe_o=0, tx_ready_o=1, rx_byte_o=0, rx_dv_o=0, underrun_o=0. Bit counter=0, shift registers=0, holding register empty, state IDLE.
- Reset asserted mid-transfer aborts immediately. After release the block waits for cs_i high before it can re-enter ACTIVE; a select already active at release is ignored until cs_i deasserts.
- Synchronization: sck_i, cs_i and mosi_i each pass through 2 flops plus a history flop. Edges are detected from synchronized vs history.
- Pin-to-internal latency is 3 clk_i cycles. Functional only if the clk_i period is at most 1/8 of the sck period.
- Leading edge = rising if CPOL=0, falling if CPOL=1. Trailing edge is the opposite.
- State IDLE:
  - miso_oe_o=0.
  - On synchronized cs falling: go to ACTIVE, clear the bit counter.
  - Load tx shift register from the holding register if full (holding becomes empty, tx_ready_o=1 next cycle). Otherwise load DEFAULT_TX and pulse underrun_o.
  - If CPHA=0, drive the MSB on miso_o in the same cycle the shift register loads.
- State ACTIVE:
  - miso_oe_o=1.
  - Sample edge: shift mosi into the rx shift register (MSB first); bit counter +1.
  - Shift edge: present the next tx bit on miso_o.
  - CPHA=1: the first leading edge presents the MSB.
  - CPHA=0: the trailing edge after bit 7 is sampled presents the MSB of the next byte.
- Byte completion, on the 8th sample edge:
  - rx_byte_o = assembled byte; rx_dv_o=1 for exactly one cycle, 1 cycle after the detected edge. There is no backpressure on rx.
  - Bit counter wraps to 0.
  - Tx shift register reloads from the holding register, or from DEFAULT_TX with an underrun_o pulse.
- Synchronized cs rising in ACTIVE: return to IDLE.
  - A partial rx byte is discarded with no rx_dv_o. The bit counter clears.
  - A holding-register byte is retained for the next selection.
  - miso_oe_o=0 on the next cycle.
- Tx handshake: transfer occurs when tx_dv_i && tx_ready_o. tx_ready_o falls the next cycle. tx_dv_i while tx_ready_o=0 is ignored (no overwrite).
- If a reload and a tx_dv_i occur in the same cycle with the holding register empty, the reload uses DEFAULT_TX (underrun) and the new byte goes into holding.
- Edges on sck_i while cs_i is high are ignored.

Test Plan:
- Mode 0, tx_byte_i=8'hA5 preloaded, master sends 8'h3C -> rx_byte_o=8'h3C with a single rx_dv_o pulse; master receives 8'hA5; underrun_o never pulses.
- Modes 1, 2, 3 (CPOL/CPHA sweep), master sends 8'h81 and slave returns 8'h7E -> both sides correct in every mode.
- Two back-to-back bytes with no cs deassert, holding refilled after the first reload -> rx 8'h11 then 8'h22 with two rx_dv_o pulses; slave returns 8'hC3 then 8'h5A.
- No tx byte loaded, master sends 8'h00 -> master receives 8'hFF; underrun_o pulses once at select.
- cs_i deasserted after 5 bits -> no rx_dv_o; the next full byte 8'hF0 is received correctly from a bit count of 0.
- rst_i asserted mid-byte with cs_i low -> all outputs at reset values; the next transaction, after cs_i has toggled high, completes normally.
